imem_fetch_arbiter: RTL

IMEM_FETCH_ARBITER -- requirements
Module: imem_fetch_arbiter

---
 rtl/imem_fetch_arbiter_pkg.sv | 23 ++
 rtl/imem_fetch_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter_pkg
// Shared constants and types for the instruction-memory fetch arbiter:
//   - XLEN selector encodings (fetch address width = 1 << (XLEN + 4))
//   - default loader starvation limit
//   - the fault NOP instruction word (addi x0, x0, 0)
//   - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package imem_fetch_arbiter_pkg;

  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  localparam int STARVE_MAX_DEF = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter
// Arbitrates a single-ported, externally instantiated instruction memory
// between the fetch pipeline and a program loader.
//   BOOT : loader owns the memory, fetch is stalled; i_ld_done moves to RUN.
//   RUN  : fetch has priority; a waiting loader write is forced through once
//          it has waited STARVE_MAX cycles, or whenever fetch is idle.
// Faulting fetches (misaligned, or above the physical address range) are
// acked without touching memory and return a NOP flagged with o_fetch_fault.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_fetch_req/adr, o_fetch_ack fetch request side
//   o_fetch_valid, o_instr,
//   o_fetch_fault, o_stall       fetch response side (one cycle after ack)
//   i_ld_valid/adr/data,
//   o_ld_ready, i_ld_done        loader write side
//   o_mem_adr/we/wdata,
//   i_mem_rdata                  memory port (1-cycle read latency, read-first)
// ---------------------------------------------------------------------------
module imem_fetch_arbiter
  import imem_fetch_arbiter_pkg::*;
#(
  parameter int XLEN       = XLEN_64B,
  parameter int ADR_W      = 20,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BOOT_LOAD  = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fetch_req,
  input  logic [(1<<(XLEN+4))-1:0]   i_fetch_adr,
  output logic                       o_fetch_ack,
  output logic                       o_fetch_valid,
  output logic [31:0]                o_instr,
  output logic                       o_fetch_fault,
  output logic                       o_stall,
  input  logic                       i_ld_valid,
  input  logic [ADR_W-1:0]           i_ld_adr,
  input  logic [31:0]                i_ld_data,
  output logic                       o_ld_ready,
  input  logic                       i_ld_done,
  output logic [ADR_W-1:0]           o_mem_adr,
  output logic                       o_mem_we,
  output logic [31:0]                o_mem_wdata,
  input  logic [31:0]                i_mem_rdata
);

  localparam int FADR_W = 1 << (XLEN + 4);
  localparam int CNT_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [CNT_W-1:0] starve_cnt;
  logic             ld_grant;
  logic             fetch_fault;
  logic             fetch_rd;
  logic [ADR_W-1:0] adr_hold;
  logic             vld_p1;
  logic             fault_p1;
  logic             unused_ld_lsb;

  // Misaligned, or any address bit beyond the physical memory range.
  function automatic logic is_fault(input logic [FADR_W-1:0] adr);
    return (adr[1:0] != 2'b00) || ((adr >> ADR_W) != '0);
  endfunction

  // Loader byte-lane bits are meaningless for word writes.
  assign unused_ld_lsb = ^i_ld_adr[1:0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= (BOOT_LOAD != 0) ? ST_BOOT : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == ST_BOOT) && i_ld_done) begin
      state_d = ST_RUN;
    end
  end

  // Grants are forced low during reset so nothing reaches memory while the
  // state is being re-established.
  always_comb begin
    ld_grant    = 1'b0;
    o_fetch_ack = 1'b0;
    o_stall     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ld_grant = !i_rst && i_ld_valid;
        o_stall  = 1'b1;
      end
      ST_RUN: begin
        ld_grant    = !i_rst && i_ld_valid &&
                      (!i_fetch_req || (starve_cnt == CNT_W'(STARVE_MAX)));
        o_fetch_ack = !i_rst && i_fetch_req && !ld_grant;
        o_stall     = i_fetch_req && !o_fetch_ack;
      end
      default: begin
        o_stall = 1'b1;
      end
    endcase
  end

  assign o_ld_ready = ld_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if ((state_q == ST_RUN) && i_ld_valid && !ld_grant) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Stage p0: memory request. Faulting fetches are acked but never issued.
  assign fetch_fault = is_fault(i_fetch_adr);
  assign fetch_rd    = o_fetch_ack && !fetch_fault;
  assign o_mem_we    = ld_grant;
  assign o_mem_wdata = i_ld_data;

  always_comb begin
    if (ld_grant) begin
      o_mem_adr = {i_ld_adr[ADR_W-1:2], 2'b00};
    end else if (fetch_rd) begin
      o_mem_adr = {i_fetch_adr[ADR_W-1:2], 2'b00};
    end else begin
      o_mem_adr = adr_hold;
    end
  end

  always_ff @(posedge i_clk) begin
    adr_hold <= o_mem_adr;
  end

  // Stage p1: read data returns; valid/fault travel with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
    end else begin
      vld_p1   <= o_fetch_ack;
      fault_p1 <= o_fetch_ack && fetch_fault;
    end
  end

  // An in-flight response is suppressed as soon as reset is seen.
  assign o_fetch_valid = vld_p1 && !i_rst;
  assign o_fetch_fault = fault_p1 && !i_rst;

  always_comb begin
    if (!o_fetch_valid) begin
      o_instr = 32'h0;
    end else if (fault_p1) begin
      o_instr = NOP_INSTR;
    end else begin
      o_instr = i_mem_rdata;
    end
  end

endmodule
